// File: rtl/bram_prefetch_reader_if.sv
// Bus bundle between the prefetch reader, the BRAM FIFO controller and the op consumer.
// The master modport is the prefetch reader; the slave modport is its surroundings.
interface bram_prefetch_reader_if #(
    parameter int unsigned DATA_BITS = 64,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned LVL_BITS  = $clog2(DEPTH + 1)
);
    // BRAM FIFO controller side
    logic                 is_empty;
    logic                 bram_rdy;
    logic                 bram_done;
    logic [DATA_BITS-1:0] bram_data;
    logic                 bram_trigger;
    // Consumer side
    logic                 reader_rdy;
    logic                 reader_done;
    logic                 reader_trigger;
    logic [DATA_BITS-1:0] reader_data;
    // Status
    logic [LVL_BITS-1:0]  level;
    logic                 busy;

    modport master (
        input  is_empty, bram_rdy, bram_done, bram_data, reader_rdy, reader_done,
        output bram_trigger, reader_trigger, reader_data, level, busy
    );

    modport slave (
        output is_empty, bram_rdy, bram_done, bram_data, reader_rdy, reader_done,
        input  bram_trigger, reader_trigger, reader_data, level, busy
    );
endinterface

// File: rtl/bram_prefetch_reader.sv
// Prefetching BRAM reader: keeps up to DEPTH words queued ahead of the op consumer so that
// BRAM read latency overlaps op execution. One fetch FSM fills the queue (one request in
// flight at most), one dispatch FSM hands words to the consumer. Supports a synchronous
// flush and exposes queue occupancy and a busy flag.
module bram_prefetch_reader #(
    parameter int unsigned DATA_BITS = 64,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clk_en,
    input  logic                   flush,
    bram_prefetch_reader_if.master bus
);
    localparam int unsigned LVL_BITS = $clog2(DEPTH + 1);
    localparam int unsigned PTR_BITS = $clog2(DEPTH);

    typedef enum logic {FIdle, FWait} fetch_state_e;
    typedef enum logic {DIdle, DBusy} disp_state_e;

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [PTR_BITS-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_BITS-1:0]  level_q, level_d;
    fetch_state_e         f_state_q, f_state_d;
    disp_state_e          d_state_q, d_state_d;
    logic                 drop_q, drop_d;
    logic                 bram_trig_q, bram_trig_d;
    logic                 rdr_trig_q, rdr_trig_d;
    logic [DATA_BITS-1:0] rdr_data_q, rdr_data_d;
    logic                 push, pop;

    // Fetch FSM: issue a read when there is room, accept the returning word unless dropped.
    // One request in flight means level < DEPTH at request time guarantees room on return.
    always_comb begin
        f_state_d   = f_state_q;
        drop_d      = drop_q;
        bram_trig_d = 1'b0;
        push        = 1'b0;
        unique case (f_state_q)
            FIdle: begin
                if (!flush && !bus.is_empty && bus.bram_rdy &&
                    (level_q < LVL_BITS'(DEPTH))) begin
                    bram_trig_d = 1'b1;
                    f_state_d   = FWait;
                end
            end
            FWait: begin
                if (bus.bram_done) begin
                    // A flush in the same cycle also discards the returning word
                    push      = !drop_q && !flush;
                    drop_d    = 1'b0;
                    f_state_d = FIdle;
                end else if (flush) begin
                    drop_d = 1'b1;
                end
            end
        endcase
    end

    // Dispatch FSM: hand the queue head to an idle consumer, then wait for it to finish.
    always_comb begin
        d_state_d  = d_state_q;
        rdr_trig_d = 1'b0;
        rdr_data_d = rdr_data_q;
        pop        = 1'b0;
        unique case (d_state_q)
            DIdle: begin
                if ((level_q != '0) && bus.reader_rdy) begin
                    pop        = 1'b1;
                    rdr_data_d = mem_q[rd_ptr_q];
                    rdr_trig_d = 1'b1;
                    d_state_d  = DBusy;
                end
            end
            DBusy: begin
                if (bus.reader_done) begin
                    d_state_d = DIdle;
                end
            end
        endcase
    end

    // Queue pointers and occupancy; flush empties the queue regardless of push/pop.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_BITS'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_BITS'(1) : rd_ptr_q;
        level_d  = level_q + LVL_BITS'(push) - LVL_BITS'(pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
    end

    // State registers; everything, including trigger pulses, holds while clk_en is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            f_state_q   <= FIdle;
            d_state_q   <= DIdle;
            drop_q      <= 1'b0;
            bram_trig_q <= 1'b0;
            rdr_trig_q  <= 1'b0;
            rdr_data_q  <= '0;
        end else if (clk_en) begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            f_state_q   <= f_state_d;
            d_state_q   <= d_state_d;
            drop_q      <= drop_d;
            bram_trig_q <= bram_trig_d;
            rdr_trig_q  <= rdr_trig_d;
            rdr_data_q  <= rdr_data_d;
        end
    end

    // Queue storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (clk_en && push) begin
            mem_q[wr_ptr_q] <= bus.bram_data;
        end
    end

    assign bus.bram_trigger   = bram_trig_q;
    assign bus.reader_trigger = rdr_trig_q;
    assign bus.reader_data    = rdr_data_q;
    assign bus.level          = level_q;
    assign bus.busy           = (f_state_q == FWait) || (level_q != '0) || (d_state_q == DBusy);
endmodule
